// File: rtl/alu_seq.sv
// alu_seq: register-file ALU with single-cycle ops and an iterative shift-add multiplier
module alu_seq #(
  parameter int NBITS = 8,
  parameter int NREGS = 8,
  parameter int RW = $clog2(NREGS),
  parameter int INSTR_W = 4 + 3 * RW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [NBITS-1:0]   res_data,
  output logic               res_valid,
  output logic [1:0]         flags,
  output logic               illegal,
  output logic [NBITS-1:0]   leds
);
  localparam int CW = $clog2(NBITS);
  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_nxt;
  logic [NBITS-1:0] regs [NREGS];
  logic [3:0] op;
  logic [RW-1:0] rd, ra, rb, mul_rd;
  logic [NBITS-1:0] a, b, r, mcand, mplier, acc, mul_sum;
  logic [NBITS:0] sum, diff;
  logic [2*RW+NBITS-1:0] imm;
  logic [CW-1:0] cnt;
  logic c, wr, take, mul_done;
  assign {op, rd, ra, rb} = instr;
  assign a = regs[ra];
  assign b = regs[rb];
  assign sum = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign imm = (2*RW+NBITS)'(instr[2*RW-1:0]);
  assign instr_ready = state == IDLE;
  assign take = instr_valid && instr_ready;
  assign leds = regs[0];
  assign mul_sum = acc + (mplier[0] ? mcand : '0);
  assign mul_done = state == MUL && cnt == CW'(NBITS-1);
  always_comb begin
    wr = 1'b1;
    c = 1'b0;
    r = '0;
    case (op)
      4'd1: {c, r} = sum;
      4'd2: {c, r} = diff;
      4'd3: r = a & b;
      4'd4: r = a | b;
      4'd5: r = a ^ b;
      4'd6: r = a << b[2:0];
      4'd7: r = a >> b[2:0];
      4'd8: r = imm[NBITS-1:0];
      default: wr = 1'b0;
    endcase
  end
  always_comb begin
    state_nxt = state;
    if (take && op == 4'd9) state_nxt = MUL;
    if (mul_done) state_nxt = IDLE;
  end
  // Accept and multiply-step paths are exclusive: take needs IDLE, stepping needs MUL
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      state <= IDLE;
      res_data <= '0;
      flags <= '0;
      res_valid <= 1'b0;
      illegal <= 1'b0;
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
      mul_rd <= '0;
    end else begin
      state <= state_nxt;
      res_valid <= 1'b0;
      illegal <= 1'b0;
      if (take && wr) begin
        regs[rd] <= r;
        res_data <= r;
        flags <= {c, r == '0};
        res_valid <= 1'b1;
      end
      if (take && op == 4'd9) begin
        mcand <= a;
        mplier <= b;
        acc <= '0;
        cnt <= '0;
        mul_rd <= rd;
      end
      if (take && op >= 4'd10) illegal <= 1'b1;
      if (state == MUL) begin
        acc <= mul_sum;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= cnt + CW'(1);
        if (mul_done) begin
          regs[mul_rd] <= mul_sum;
          res_data <= mul_sum;
          flags <= {1'b0, mul_sum == '0};
          res_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed scoreboard bench for alu_seq (NBITS=8, NREGS=8)
module tb_alu_seq;
  logic clk = 1'b0, reset = 1'b0, instr_valid = 1'b0;
  logic [12:0] instr = '0;
  logic instr_ready, res_valid, illegal;
  logic [7:0] res_data, leds;
  logic [1:0] flags;
  int tests = 0, fails = 0, cyc = 0;
  int last_acc, waited, acc_m, acc_h;
  typedef struct {logic ill; logic [7:0] d; logic [1:0] f;} exp_t;
  exp_t q[$];
  int vlog[$];

  alu_seq dut (.clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .res_data(res_data), .res_valid(res_valid),
    .flags(flags), .illegal(illegal), .leds(leds));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [2:0] rd, ra, rb,
                      input logic push, input logic ill, input logic [7:0] d, input logic [1:0] f);
    exp_t e;
    int n;
    @(negedge clk);
    instr = {op, rd, ra, rb};
    instr_valid = 1'b1;
    if (push) begin
      e.ill = ill; e.d = d; e.f = f;
      q.push_back(e);
    end
    n = 0;
    while (!instr_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!instr_ready) begin
      tests++; fails++;
      $display("FAIL accept timeout: instr_ready stuck at 0");
    end
    waited = n;
    @(posedge clk);
    #1;
    last_acc = cyc;
    instr_valid = 1'b0;
  endtask

  task automatic op3(input logic [3:0] op, input logic [2:0] rd, ra, rb, input logic [7:0] d, input logic [1:0] f);
    send(op, rd, ra, rb, 1'b1, 1'b0, d, f);
  endtask

  task automatic ldi(input logic [2:0] rd, input logic [5:0] imm);
    send(4'd8, rd, imm[5:3], imm[2:0], 1'b1, 1'b0, {2'b00, imm}, 2'b00);
  endtask

  always @(negedge clk) begin
    if (reset && (res_valid || illegal)) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected output: res_valid=%0b illegal=%0b res_data=%0h", res_valid, illegal, res_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.ill !== illegal || e.ill === res_valid || (!e.ill && (res_data !== e.d || flags !== e.f))) begin
          fails++;
          $display("FAIL result: got ill=%0b data=%0h flags=%0b expected ill=%0b data=%0h flags=%0b",
                   illegal, res_data, flags, e.ill, e.d, e.f);
        end
      end
      if (res_valid) vlog.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset res_data", res_data, 0);
    chk("reset flags", flags, 0);
    chk("reset res_valid", res_valid, 0);
    chk("reset illegal", illegal, 0);
    chk("reset leds", leds, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready after reset", instr_ready, 1);
    // back-to-back single-cycle ops with read-after-write
    ldi(3'd1, 6'h2A);
    ldi(3'd2, 6'h0F);
    op3(4'd1, 3'd3, 3'd1, 3'd2, 8'h39, 2'b00);
    repeat (3) @(negedge clk);
    chk("b2b gap1", vlog[$-1] - vlog[$-2], 1);
    chk("b2b gap2", vlog[$] - vlog[$-1], 1);
    ldi(3'd1, 6'h01);
    op3(4'd2, 3'd4, 3'd0, 3'd1, 8'hFF, 2'b10);
    op3(4'd5, 3'd5, 3'd4, 3'd4, 8'h00, 2'b01);
    op3(4'd3, 3'd6, 3'd3, 3'd2, 8'h09, 2'b00);
    op3(4'd4, 3'd6, 3'd3, 3'd1, 8'h39, 2'b00);
    op3(4'd6, 3'd7, 3'd3, 3'd2, 8'h80, 2'b00);
    op3(4'd7, 3'd7, 3'd3, 3'd2, 8'h00, 2'b01);
    op3(4'd1, 3'd6, 3'd4, 3'd1, 8'h00, 2'b11);
    op3(4'd1, 3'd7, 3'd6, 3'd3, 8'h39, 2'b00);
    op3(4'd1, 3'd3, 3'd3, 3'd3, 8'h72, 2'b00);
    op3(4'd2, 3'd7, 3'd3, 3'd1, 8'h71, 2'b00);
    send(4'd0, 3'd1, 3'd1, 3'd1, 1'b0, 1'b0, 8'h00, 2'b00);
    // multiply with an instruction held valid behind it
    ldi(3'd1, 6'h0D);
    ldi(3'd2, 6'h0B);
    op3(4'd9, 3'd3, 3'd1, 3'd2, 8'h8F, 2'b00);
    acc_m = last_acc;
    op3(4'd1, 3'd4, 3'd3, 3'd1, 8'h9C, 2'b00);
    acc_h = last_acc;
    chk("mul ready-low cycles", waited, 8);
    chk("held accept offset", acc_h - acc_m, 9);
    repeat (3) @(negedge clk);
    chk("mul valid offset", vlog[$-1] + 1 - acc_m, 9);
    op3(4'd9, 3'd5, 3'd3, 3'd2, 8'h25, 2'b00);
    op3(4'd9, 3'd6, 3'd1, 3'd0, 8'h00, 2'b01);
    // reset during the 4th multiply cycle
    send(4'd9, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0, 8'h00, 2'b00);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midmul res_data", res_data, 0);
    chk("midmul flags", flags, 0);
    chk("midmul res_valid", res_valid, 0);
    chk("midmul leds", leds, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("ready after midmul reset", instr_ready, 1);
    repeat (10) @(negedge clk);
    op3(4'd4, 3'd7, 3'd3, 3'd3, 8'h00, 2'b01);
    // undefined opcode then LDI to r0
    ldi(3'd1, 6'h05);
    send(4'hC, 3'd2, 3'd1, 3'd1, 1'b1, 1'b1, 8'h00, 2'b00);
    @(negedge clk);
    chk("illegal holds res_data", res_data, 8'h05);
    chk("illegal holds flags", flags, 2'b00);
    op3(4'd4, 3'd3, 3'd2, 3'd2, 8'h00, 2'b01);
    ldi(3'd0, 6'h33);
    @(negedge clk);
    chk("leds", leds, 8'h33);
    repeat (5) @(negedge clk);
    chk("scoreboard drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
